// File: rtl/core_pkg.sv
// Opcode, sub-op and FSM encodings shared by multicycle_core and core_alu.
// Macro CORE_MUL_EN enables the mul instruction (Op0=7, Op1=1).
package core_pkg;

   localparam logic [3:0] JrOrTrap = 4'h0;
   localparam logic [3:0] Not      = 4'h1;
   localparam logic [3:0] AnyOrNeg = 4'h3;
   localparam logic [3:0] LdOrSt   = 4'h4;
   localparam logic [3:0] Bitwise  = 4'h5;
   localparam logic [3:0] IntArith = 4'h7;
   localparam logic [3:0] Ci8      = 4'hB;
   localparam logic [3:0] Cup      = 4'hD;
   localparam logic [3:0] Bz       = 4'hE;
   localparam logic [3:0] Bnz      = 4'hF;

   localparam logic [3:0] OP1_TRAP  = 4'h0;
   localparam logic [3:0] OP1_JR    = 4'h1;
   localparam logic [3:0] OP1_ANY   = 4'h0;
   localparam logic [3:0] OP1_NEG   = 4'h1;
   localparam logic [3:0] OP1_LD    = 4'h0;
   localparam logic [3:0] OP1_ST    = 4'h1;
   localparam logic [3:0] OP1_AND   = 4'h0;
   localparam logic [3:0] OP1_OR    = 4'h1;
   localparam logic [3:0] OP1_XOR   = 4'h2;
   localparam logic [3:0] OP1_SHIFT = 4'h3;
   localparam logic [3:0] OP1_ADD   = 4'h0;
   localparam logic [3:0] OP1_MUL   = 4'h1;
   localparam logic [3:0] OP1_SLT   = 4'h2;

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   localparam logic [7:0] TRAP_ILLEGAL = 8'hFF;

`ifdef CORE_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   // Op1 is ignored by not and overlaps Imm8 for ci8/cup/bz/bnz.
   function automatic logic op1_legal(input logic [3:0] op0, input logic [3:0] op1);
      case (op0)
         JrOrTrap:              return (op1 == OP1_TRAP) || (op1 == OP1_JR);
         Not, Ci8, Cup, Bz, Bnz: return 1'b1;
         AnyOrNeg:              return (op1 == OP1_ANY) || (op1 == OP1_NEG);
         LdOrSt:                return (op1 == OP1_LD) || (op1 == OP1_ST);
         Bitwise:               return (op1 == OP1_AND) || (op1 == OP1_OR) ||
                                       (op1 == OP1_XOR) || (op1 == OP1_SHIFT);
         IntArith:              return (op1 == OP1_ADD) || (op1 == OP1_SLT) ||
                                       (MUL_EN && (op1 == OP1_MUL));
         default:               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for multicycle_core; a = r[d], b = r[s] or sign-extended Imm8.
// The multiplier exists only when CORE_MUL_EN is defined.
module core_alu
   import core_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [3:0]       op0,
   input  logic [3:0]       op1,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] mag;

`ifdef CORE_MUL_EN
   logic [WIDTH-1:0] product;
   assign product = a * b;
`endif

   // Signed shift amount: non-negative shifts left, negative shifts right logically.
   always_comb begin
      shifted = '0;
      mag     = '0;
      if (!b[WIDTH-1]) begin
         if (b < W_LIM) shifted = a << b;
      end else begin
         mag = -b;
         if (mag < W_LIM) shifted = a >> mag;
      end
   end

   always_comb begin
      result = '0;
      case (op0)
         Not:      result = ~b;
         AnyOrNeg: result = (op1 == OP1_NEG) ? -a : {{(WIDTH-1){1'b0}}, |a};
         Bitwise: begin
            case (op1)
               OP1_AND:   result = a & b;
               OP1_OR:    result = a | b;
               OP1_XOR:   result = a ^ b;
               OP1_SHIFT: result = shifted;
               default:   result = '0;
            endcase
         end
         IntArith: begin
            case (op1)
               OP1_ADD: result = a + b;
`ifdef CORE_MUL_EN
               OP1_MUL: result = product;
`endif
               OP1_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
               default: result = '0;
            endcase
         end
         Ci8:      result = b;
         Cup:      result = {b[7:0], a[WIDTH-9:0]};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle fetch/decode/execute core with req/ack instruction and data ports.
// Macro CORE_MUL_EN builds the multiplier; otherwise mul decodes as illegal.
module multicycle_core
   import core_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      NREGS    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic             halt,
   output logic [7:0]       trap_code,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [15:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   input  logic             dmem_ack,
   input  logic [WIDTH-1:0] dmem_rdata
);

   localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [2:0]       state;
   logic [WIDTH-1:0] pc;
   logic [15:0]      ir;
   logic [WIDTH-1:0] rd_val;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] regs [2**RW];
   logic [WIDTH-1:0] alu_result;

   logic [3:0]       op0, op1, fs, fd;
   logic [RW-1:0]    fs_i, fd_i;
   logic [WIDTH-1:0] imm_sx;
   logic             uses_d, uses_s, illegal;

   assign op0    = ir[15:12];
   assign op1    = ir[11:8];
   assign fs     = ir[7:4];
   assign fd     = ir[3:0];
   assign fs_i   = fs[RW-1:0];
   assign fd_i   = fd[RW-1:0];
   assign imm_sx = {{(WIDTH-8){ir[11]}}, ir[11:4]};

   assign uses_d  = !((op0 == JrOrTrap) && (op1 == OP1_TRAP));
   assign uses_s  = op0 inside {Not, LdOrSt, Bitwise, IntArith};
   assign illegal = !op1_legal(op0, op1) ||
                    (uses_d && (32'(fd) >= NREGS)) ||
                    (uses_s && (32'(fs) >= NREGS));

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;

   core_alu #(.WIDTH(WIDTH)) u_alu (
      .op0    (op0),
      .op1    (op1),
      .a      (rd_val),
      .b      (rs_val),
      .result (alu_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         rd_val     <= '0;
         rs_val     <= '0;
         regs       <= '{default: '0};
         halt       <= 1'b0;
         trap_code  <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  pc    <= pc + WIDTH'(1);
                  state <= DECODE;
               end
            end
            // ci8/cup carry their immediate through the b operand.
            DECODE: begin
               rd_val <= regs[fd_i];
               rs_val <= (op0 == Ci8 || op0 == Cup) ? imm_sx : regs[fs_i];
               if (illegal) begin
                  halt      <= 1'b1;
                  trap_code <= TRAP_ILLEGAL;
                  state     <= HALT;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               state <= FETCH;
               case (op0)
                  JrOrTrap: begin
                     if (op1 == OP1_TRAP) begin
                        halt      <= 1'b1;
                        trap_code <= ir[7:0];
                        state     <= HALT;
                     end else begin
                        pc <= rd_val;
                     end
                  end
                  LdOrSt: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op1 == OP1_ST);
                     dmem_addr  <= rs_val;
                     dmem_wdata <= rd_val;
                     state      <= MEM;
                  end
                  Bz:      if (rd_val == '0) pc <= pc + imm_sx;
                  Bnz:     if (rd_val != '0) pc <= pc + imm_sx;
                  default: regs[fd_i] <= alu_result;
               endcase
            end
            MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) regs[fd_i] <= dmem_rdata;
                  state <= FETCH;
               end
            end
            HALT:    state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: instruction-level reference model driven by directed and random programs.
// Build with CORE_MUL_EN defined to expect mul to execute instead of trapping.
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        halt;
   logic [7:0]  trap_code;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [15:0] dmem_rdata = '0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          fetch_cyc = 0;
   int          fetch_cyc_prev = 0;
   bit          abort = 0;

   logic [15:0] m_r [16];
   logic [15:0] m_pc;
   logic [15:0] mem [logic [15:0]];

   multicycle_core #(.WIDTH(16), .NREGS(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .halt       (halt),
      .trap_code  (trap_code),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // ISA-level model; kind: 0 plain, 1 load, 2 store, 3 halt.
   task automatic model_step(input logic [15:0] ins, output int kind, output logic [15:0] maddr,
                             output logic [15:0] mwdata, output logic [7:0] code);
      logic [3:0]  o0, o1, s, d;
      logic [15:0] a, b, sx;
      int          sh;
      bit          legal;
      o0 = ins[15:12]; o1 = ins[11:8]; s = ins[7:4]; d = ins[3:0];
      a = m_r[d]; b = m_r[s];
      sx = 16'($signed(ins[11:4]));
      kind = 0; maddr = '0; mwdata = '0; code = '0; legal = 1;
      m_pc = m_pc + 16'd1;
      case (o0)
         4'h0: if (o1 == 0) begin kind = 3; code = ins[7:0]; end
               else if (o1 == 1) m_pc = a;
               else legal = 0;
         4'h1: m_r[d] = ~b;
         4'h3: if (o1 == 0) m_r[d] = (a != 0) ? 16'd1 : 16'd0;
               else if (o1 == 1) m_r[d] = 16'd0 - a;
               else legal = 0;
         4'h4: if (o1 < 2) begin kind = (o1 == 0) ? 1 : 2; maddr = b; mwdata = a; end
               else legal = 0;
         4'h5: case (o1)
                  0: m_r[d] = a & b;
                  1: m_r[d] = a | b;
                  2: m_r[d] = a ^ b;
                  3: begin
                     sh = int'($signed(b));
                     if (sh >= 0) m_r[d] = (sh >= 16) ? 16'd0 : 16'(a << sh);
                     else         m_r[d] = (-sh >= 16) ? 16'd0 : 16'(a >> (-sh));
                  end
                  default: legal = 0;
               endcase
         4'h7: case (o1)
                  0: m_r[d] = 16'(int'(a) + int'(b));
`ifdef CORE_MUL_EN
                  1: m_r[d] = 16'(int'(a) * int'(b));
`endif
                  2: m_r[d] = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                  default: legal = 0;
               endcase
         4'hB: m_r[d] = sx;
         4'hD: m_r[d] = {ins[11:4], a[7:0]};
         4'hE: if (a == 0) m_pc = m_pc + sx;
         4'hF: if (a != 0) m_pc = m_pc + sx;
         default: legal = 0;
      endcase
      if (!legal) begin kind = 3; code = 8'hFF; end
   endtask

   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_halt", halt, 0);
      check_eq("rst_trap_code", trap_code, 0);
      check_eq("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 0);
      check_eq("rst_imem_req", imem_req, 1);
      check_eq("rst_imem_addr", imem_addr, 16'h0000);
      m_pc = 16'h0000;
      foreach (m_r[i]) m_r[i] = '0;
      mem.delete();
      abort = 0;
   endtask

   task automatic run_instr(input logic [15:0] ins, input int idly, input int ddly, input bit hold_mem);
      int          kind, waited;
      logic [15:0] maddr, mwdata, ld_val;
      logic [7:0]  code;
      if (abort) return;
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
      if (imem_req !== 1'b1) begin check_eq("fetch_timeout", imem_req, 1); abort = 1; return; end
      fetch_cyc_prev = fetch_cyc;
      fetch_cyc = cyc;
      check_eq("fetch_addr", imem_addr, m_pc);
      check_eq("run_no_halt", halt, 0);
      repeat (idly) begin
         @(negedge clk);
         check_eq("fetch_hold", {imem_req, imem_addr}, {1'b1, m_pc});
      end
      imem_ack = 1'b1; imem_rdata = ins;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
      model_step(ins, kind, maddr, mwdata, code);
      if (kind == 1 || kind == 2) begin
         waited = 0;
         while (dmem_req !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
         check_eq("dmem_req", dmem_req, 1);
         if (dmem_req !== 1'b1) begin abort = 1; return; end
         if (hold_mem) return;
         for (int i = 0; i <= ddly; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("dmem_req_hold", dmem_req, 1);
            check_eq("dmem_we", dmem_we, kind == 2);
            check_eq("dmem_addr", dmem_addr, maddr);
            if (kind == 2) check_eq("dmem_wdata", dmem_wdata, mwdata);
         end
         if (!mem.exists(maddr)) mem[maddr] = 16'($urandom);
         ld_val = mem[maddr];
         dmem_ack = 1'b1; dmem_rdata = ld_val;
         if (kind == 2) mem[maddr] = mwdata;
         else           m_r[ins[3:0]] = ld_val;
         @(negedge clk);
         dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
         check_eq("dmem_release", dmem_req, 0);
      end else if (kind == 3) begin
         repeat (2) @(negedge clk);
         check_eq("halt", halt, 1);
         check_eq("trap_code", trap_code, code);
         check_eq("halt_imem_req", imem_req, 0);
         imem_ack = 1'b1; imem_rdata = 16'hB011;
         @(negedge clk);
         imem_ack = 1'b0;
         @(negedge clk);
         check_eq("halt_sticky", {halt, imem_req, trap_code}, {1'b1, 1'b0, code});
         check_eq("halt_pc", imem_addr, m_pc);
      end
   endtask

   function automatic logic [15:0] rand_legal();
      logic [3:0] s, d;
      logic [7:0] imm;
      s = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      imm = 8'($urandom);
      case ($urandom_range(0, 13))
         0, 1:    return {4'hB, imm, d};
         2:       return {4'hB, 8'($urandom_range(0, 40) - 20), d};
         3:       return {4'hD, imm, d};
         4:       return {4'h1, 4'($urandom), s, d};
         5:       return {4'h3, 3'b000, 1'($urandom), s, d};
         6:       return {4'h5, 2'b00, 2'($urandom), s, d};
`ifdef CORE_MUL_EN
         7:       return {4'h7, 4'($urandom_range(0, 2)), s, d};
`else
         7:       return {4'h7, ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h0, s, d};
`endif
         8:       return {4'h4, 4'h0, s, d};
         9:       return {4'h4, 4'h1, s, d};
         10:      return {4'hE, 8'($urandom_range(0, 8) - 4), d};
         11:      return {4'hF, 8'($urandom_range(0, 8) - 4), d};
         12:      return {4'h0, 4'h1, s, d};
         default: return {4'h5, 4'h3, s, d};
      endcase
   endfunction

   function automatic logic [15:0] rand_halting();
      logic [3:0] bad_op0 [6];
      bad_op0 = '{4'h2, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC};
      case ($urandom_range(0, 2))
         0:       return {8'h00, 8'($urandom)};
         1:       return {bad_op0[$urandom_range(0, 5)], 12'($urandom)};
         default: return {4'h0, 4'($urandom_range(2, 15)), 8'($urandom)};
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ci8/ci8/add at three cycles each, then trap 0x2A.
      do_reset();
      run_instr(16'hBFD1, 0, 0, 0);
      run_instr(16'hB052, 0, 0, 0);
      check_eq("cpi_ci8", fetch_cyc - fetch_cyc_prev, 3);
      run_instr(16'h7021, 0, 0, 0);
      check_eq("cpi_ci8b", fetch_cyc - fetch_cyc_prev, 3);
      run_instr(16'h4121, 0, 0, 0);
      check_eq("cpi_add", fetch_cyc - fetch_cyc_prev, 3);
      run_instr(16'h002A, 0, 0, 0);
      check_eq("cpi_st", fetch_cyc - fetch_cyc_prev, 4);

      // cup over ci8, delayed store, then load back and store again.
      do_reset();
      run_instr(16'hB343, 0, 0, 0);
      run_instr(16'hD123, 0, 0, 0);
      run_instr(16'hB004, 0, 0, 0);
      run_instr(16'hD014, 0, 0, 0);
      run_instr(16'h4143, 0, 3, 0);
      run_instr(16'h4045, 0, 0, 0);
      run_instr(16'h4145, 0, 0, 0);
      check_eq("cpi_ld", fetch_cyc - fetch_cyc_prev, 4);
      run_instr(16'h8000, 0, 0, 0);

      // Taken bz backwards, untaken bnz, then trap.
      do_reset();
      run_instr(16'hB006, 0, 0, 0);
      run_instr(16'hB017, 0, 0, 0);
      run_instr(16'hEFE6, 0, 0, 0);
      run_instr(16'hF056, 1, 0, 0);
      run_instr(16'h4176, 0, 0, 0);
      run_instr(16'h0055, 0, 0, 0);

      // Reset while a load is waiting for dmem_ack.
      do_reset();
      run_instr(16'hB100, 0, 0, 0);
      run_instr(16'h4001, 0, 0, 1);
      do_reset();

      // mul 3*7.
      run_instr(16'hB031, 0, 0, 0);
      run_instr(16'hB072, 0, 0, 0);
      run_instr(16'h7121, 0, 0, 0);
`ifdef CORE_MUL_EN
      run_instr(16'h4121, 0, 0, 0);
      run_instr(16'h0001, 0, 0, 0);
`endif

      for (int p = 0; p < 6; p++) begin
         do_reset();
         for (int k = 0; k < 40; k++)
            run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
         for (int r = 0; r < 16; r++)
            run_instr({4'h4, 4'h1, 4'($urandom_range(0, 15)), 4'(r)}, 0, $urandom_range(0, 1), 0);
         run_instr(rand_halting(), $urandom_range(0, 1), 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
